// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, word-length codes and helpers for uart_core.
// Parity logic is compiled in only when UART_CORE_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [1:0] BITS5 = 2'b00;
    localparam logic [1:0] BITS6 = 2'b01;
    localparam logic [1:0] BITS7 = 2'b10;
    localparam logic [1:0] BITS8 = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic logic [3:0] nbits(input logic [1:0] b);
        unique case (b)
            BITS5:   return 4'd5;
            BITS6:   return 4'd6;
            BITS7:   return 4'd7;
            BITS8:   return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] word_mask(input logic [1:0] b);
        return 8'hff >> (4'd8 - nbits(b));
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO with occupancy output.
// Part of uart_core (optional parity via UART_CORE_PARITY_EN).
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_rd   = rd_en && !empty;
    // a pop frees the slot in the same cycle, so a full FIFO may still take a write
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_core.sv
// uart_core: UART with TX/RX FIFOs, 5..8 data bits, 1/2 stop bits.
// Parity generation/check compiled in with UART_CORE_PARITY_EN.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    localparam int LW = clog2(DATA_DEPTH) + 1
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst_n,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic [1:0]           i_data_bits,
    input  logic                 i_stop2,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_loopback,
    input  logic [7:0]           i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [7:0]           o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_overrun,
    input  logic                 i_clr_overrun,
    output logic [LW-1:0]        o_tx_level,
    output logic [LW-1:0]        o_rx_level,
    input  logic                 i_rx,
    output logic                 o_tx,
    output logic                 o_tx_busy
);

    logic par_en;
    logic par_odd;

    state_t               tx_st;
    logic [DIV_WIDTH-1:0] tx_cnt;
    logic [DIV_WIDTH-1:0] tx_div;
    logic [7:0]           tx_q;
    logic [7:0]           tx_sh;
    logic [3:0]           tx_bit;
    logic [3:0]           tx_nb;
    logic                 tx_empty;
    logic                 tx_full;
    logic                 tx_pop;
    logic                 tx_tick;
    logic                 tx_stop2;
    logic                 tx_pen;
    logic                 tx_par;

    assign o_tx_ready = !tx_full;
    assign tx_tick    = tx_cnt == tx_div;
    // reloading straight out of the last stop bit keeps frames gapless
    assign tx_pop     = !tx_empty && (tx_st == S_IDLE ||
                        (tx_st == S_STOP && tx_tick && !tx_stop2));

    uart_fifo #(.WIDTH(8), .DEPTH(DATA_DEPTH)) u_tx_fifo (
        .clk     (i_sys_clk),
        .rst_n   (i_sys_rst_n),
        .wr_en   (i_tx_valid && o_tx_ready),
        .wr_data (i_tx_data),
        .rd_en   (tx_pop),
        .rd_data (tx_q),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (o_tx_level)
    );

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            tx_st     <= S_IDLE;
            o_tx      <= 1'b1;
            o_tx_busy <= 1'b0;
            tx_cnt    <= '0;
            tx_div    <= '0;
            tx_sh     <= '0;
            tx_bit    <= '0;
            tx_nb     <= '0;
            tx_stop2  <= 1'b0;
            tx_pen    <= 1'b0;
            tx_par    <= 1'b0;
        end else if (tx_pop) begin
            tx_st     <= S_START;
            o_tx      <= 1'b0;
            o_tx_busy <= 1'b1;
            tx_cnt    <= '0;
            tx_div    <= i_baud_div;
            tx_sh     <= tx_q;
            tx_bit    <= '0;
            tx_nb     <= nbits(i_data_bits);
            tx_stop2  <= i_stop2;
            tx_pen    <= par_en;
            tx_par    <= par_odd ^ (^(tx_q & word_mask(i_data_bits)));
        end else if (tx_st != S_IDLE) begin
            tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
            if (tx_tick) begin
                unique case (tx_st)
                    S_START: begin
                        tx_st  <= S_DATA;
                        o_tx   <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_bit <= 4'd1;
                    end
                    S_DATA: begin
                        if (tx_bit == tx_nb) begin
                            tx_st <= tx_pen ? S_PARITY : S_STOP;
                            o_tx  <= tx_pen ? tx_par : 1'b1;
                        end else begin
                            o_tx   <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                            tx_bit <= tx_bit + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        tx_st <= S_STOP;
                        o_tx  <= 1'b1;
                    end
                    S_STOP: begin
                        if (tx_stop2) begin
                            tx_stop2 <= 1'b0;
                        end else begin
                            tx_st     <= S_IDLE;
                            o_tx_busy <= 1'b0;
                        end
                    end
                    default: tx_st <= S_IDLE;
                endcase
            end
        end
    end

    logic                 rx_line;
    logic                 rx_m;
    logic                 rx_s;
    logic                 rx_prev;
    state_t               rx_st;
    logic [DIV_WIDTH-1:0] rx_cnt;
    logic [DIV_WIDTH-1:0] rx_div;
    logic [7:0]           rx_sh;
    logic [3:0]           rx_bit;
    logic [3:0]           rx_nb;
    logic                 rx_pen;
    logic                 rx_odd;
    logic                 rx_par;
    logic                 rx_perr;
    logic                 rx_tick;
    logic                 rx_push;
    logic [9:0]           rx_wd;
    logic [9:0]           rx_q;
    logic                 rx_full;
    logic                 rx_empty;

    assign rx_line = i_loopback ? o_tx : i_rx;
    assign rx_tick = rx_cnt == (rx_st == S_START ? rx_div >> 1 : rx_div);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx_line;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            rx_st   <= S_IDLE;
            rx_cnt  <= '0;
            rx_div  <= '0;
            rx_sh   <= '0;
            rx_bit  <= '0;
            rx_nb   <= '0;
            rx_pen  <= 1'b0;
            rx_odd  <= 1'b0;
            rx_par  <= 1'b0;
            rx_perr <= 1'b0;
            rx_push <= 1'b0;
            rx_wd   <= '0;
        end else begin
            rx_push <= 1'b0;
            if (rx_st != S_IDLE) rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
            unique case (rx_st)
                S_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_st  <= S_START;
                        rx_cnt <= '0;
                        rx_div <= i_baud_div;
                        rx_nb  <= nbits(i_data_bits);
                        rx_pen <= par_en;
                        rx_odd <= par_odd;
                    end
                end
                S_START: begin
                    if (rx_tick) begin
                        rx_st   <= rx_s ? S_IDLE : S_DATA;
                        rx_bit  <= '0;
                        rx_par  <= 1'b0;
                        rx_perr <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_par <= rx_par ^ rx_s;
                        rx_bit <= rx_bit + 4'd1;
                        if (rx_bit + 4'd1 == rx_nb)
                            rx_st <= rx_pen ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (rx_tick) begin
                        rx_perr <= rx_par ^ rx_s ^ rx_odd;
                        rx_st   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // the word sits in the top bits of the shifter; realign to bit 0
                    if (rx_tick) begin
                        rx_push <= 1'b1;
                        rx_wd   <= {rx_perr, !rx_s, rx_sh >> (4'd8 - rx_nb)};
                        rx_st   <= S_IDLE;
                    end
                end
                default: rx_st <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) o_rx_overrun <= 1'b0;
        else if (rx_push && rx_full) o_rx_overrun <= 1'b1;
        else if (i_clr_overrun) o_rx_overrun <= 1'b0;
    end

    uart_fifo #(.WIDTH(10), .DEPTH(DATA_DEPTH)) u_rx_fifo (
        .clk     (i_sys_clk),
        .rst_n   (i_sys_rst_n),
        .wr_en   (rx_push && !rx_full),
        .wr_data (rx_wd),
        .rd_en   (i_rx_ready),
        .rd_data (rx_q),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (o_rx_level)
    );

    assign o_rx_valid     = !rx_empty;
    assign o_rx_data      = rx_empty ? 8'h00 : rx_q[7:0];
    assign o_rx_frame_err = !rx_empty && rx_q[8];

`ifdef UART_CORE_PARITY_EN
    assign par_en          = i_parity_en;
    assign par_odd         = i_parity_odd;
    assign o_rx_parity_err = !rx_empty && rx_q[9];
`else
    logic unused_par;
    assign par_en          = 1'b0;
    assign par_odd         = 1'b0;
    assign o_rx_parity_err = 1'b0;
    assign unused_par      = i_parity_en ^ i_parity_odd ^ rx_q[9];
`endif

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed scoreboard bench for uart_core.
// Parity-specific steps run only when UART_CORE_PARITY_EN is defined.
module tb_uart_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [15:0] i_baud_div;
    logic [1:0] i_data_bits;
    logic       i_stop2, i_parity_en, i_parity_odd, i_loopback;
    logic [7:0] i_tx_data;
    logic       i_tx_valid, o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid, i_rx_ready;
    logic       o_rx_frame_err, o_rx_parity_err, o_rx_overrun, i_clr_overrun;
    logic [4:0] o_tx_level, o_rx_level;
    logic       i_rx, o_tx, o_tx_busy;

    int n_pass = 0;
    int n_total = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    uart_core #(.DATA_DEPTH(16), .DIV_WIDTH(16)) dut (
        .i_sys_clk       (clk),
        .i_sys_rst_n     (rst_n),
        .i_baud_div      (i_baud_div),
        .i_data_bits     (i_data_bits),
        .i_stop2         (i_stop2),
        .i_parity_en     (i_parity_en),
        .i_parity_odd    (i_parity_odd),
        .i_loopback      (i_loopback),
        .i_tx_data       (i_tx_data),
        .i_tx_valid      (i_tx_valid),
        .o_tx_ready      (o_tx_ready),
        .o_rx_data       (o_rx_data),
        .o_rx_valid      (o_rx_valid),
        .i_rx_ready      (i_rx_ready),
        .o_rx_frame_err  (o_rx_frame_err),
        .o_rx_parity_err (o_rx_parity_err),
        .o_rx_overrun    (o_rx_overrun),
        .i_clr_overrun   (i_clr_overrun),
        .o_tx_level      (o_tx_level),
        .o_rx_level      (o_rx_level),
        .i_rx            (i_rx),
        .o_tx            (o_tx),
        .o_tx_busy       (o_tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tx_write(input logic [7:0] d);
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        @(negedge clk);
        i_tx_valid = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int t = 0;
        while (o_tx !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(tag, (t < 200) ? 1 : 0, 1);
    endtask

    task automatic wait_tx_idle(input string tag);
        int t = 0;
        while (o_tx_busy !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(tag, (t < 1000) ? 1 : 0, 1);
    endtask

    task automatic rx_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            i_rx = bits[i];
            repeat (16) @(negedge clk);
        end
        i_rx = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    task automatic rx_expect(input string tag);
        int t = 0;
        logic [9:0] e;
        while (!o_rx_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_wait"}, (t < 2000) ? 1 : 0, 1);
        e = (sb.size() > 0) ? sb.pop_front() : 10'h3ff;
        check(tag, {22'd0, o_rx_parity_err, o_rx_frame_err, o_rx_data},
              {22'd0, e});
        i_rx_ready = 1'b1;
        @(negedge clk);
        i_rx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp_bits;
        logic [10:0] cap;
        logic [7:0]  d;
        int          n_bits;
        int          lo;
        int          acc;
        int          k;
        logic        seen;

        i_baud_div = 16'd15;
        i_data_bits = 2'b11;
        i_stop2 = 1'b0;
        i_parity_en = 1'b0;
        i_parity_odd = 1'b0;
        i_loopback = 1'b0;
        i_tx_data = 8'h00;
        i_tx_valid = 1'b0;
        i_rx_ready = 1'b0;
        i_clr_overrun = 1'b0;
        i_rx = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_tx", o_tx, 1);
        check("rst_busy", o_tx_busy, 0);
        check("rst_ready", o_tx_ready, 1);
        check("rst_rx_valid", o_rx_valid, 0);
        check("rst_rx_data", o_rx_data, 0);
        check("rst_errs", {o_rx_frame_err, o_rx_parity_err, o_rx_overrun}, 0);
        check("rst_levels", {o_tx_level, o_rx_level}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // loopback 0xA5, 8N1
        i_loopback = 1'b1;
        sb.push_back({2'b00, 8'hA5});
        tx_write(8'hA5);
        wait_tx_low("lb_start");
        check("lb_busy", o_tx_busy, 1);
        lo = 0;
        while (o_tx === 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        check("lb_start_len", lo, 16);
        rx_expect("lb_a5");
        wait_tx_idle("lb_idle");

        // 7 bits, odd parity, 2 stop bits, 0x55
        i_data_bits = 2'b10;
        i_parity_en = 1'b1;
        i_parity_odd = 1'b1;
        i_stop2 = 1'b1;
`ifdef UART_CORE_PARITY_EN
        exp_bits = {1'b1, 1'b1, 1'b1, 7'h55, 1'b0};
        n_bits = 11;
`else
        exp_bits = {1'b0, 1'b1, 1'b1, 7'h55, 1'b0};
        n_bits = 10;
`endif
        sb.push_back({2'b00, 8'h55});
        tx_write(8'h55);
        wait_tx_low("fmt_start");
        cap = '0;
        repeat (8) @(negedge clk);
        cap[0] = o_tx;
        for (int i = 1; i < n_bits; i++) begin
            repeat (16) @(negedge clk);
            cap[i] = o_tx;
        end
        check("fmt_bits", cap, exp_bits);
        check("fmt_busy_last_stop", o_tx_busy, 1);
        rx_expect("fmt_rx");
        wait_tx_idle("fmt_idle");
        check("fmt_idle_line", o_tx, 1);

        i_data_bits = 2'b11;
        i_parity_en = 1'b0;
        i_parity_odd = 1'b0;
        i_stop2 = 1'b0;
        i_loopback = 1'b0;
        repeat (4) @(negedge clk);

        // error injection on i_rx
        sb.push_back({2'b01, 8'h3C});
        rx_bits({6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        rx_expect("frame_err");
        sb.push_back({2'b00, 8'hC3});
        rx_bits({6'b0, 1'b1, 8'hC3, 1'b0}, 10);
        rx_expect("frame_ok_next");
`ifdef UART_CORE_PARITY_EN
        i_parity_en = 1'b1;
        sb.push_back({2'b10, 8'h3C});
        rx_bits({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        rx_expect("parity_err");
        sb.push_back({2'b00, 8'h3C});
        rx_bits({5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        rx_expect("parity_ok");
        i_parity_en = 1'b0;
`endif

        // overrun: 17 frames into a 16-deep RX FIFO
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 37 + 5);
            if (i < 16) sb.push_back({2'b00, d});
            if (i == 16) begin
                check("ovr_level16", o_rx_level, 16);
                check("ovr_not_yet", o_rx_overrun, 0);
            end
            rx_bits({6'b0, 1'b1, d, 1'b0}, 10);
        end
        check("ovr_level", o_rx_level, 16);
        check("ovr_flag", o_rx_overrun, 1);
        i_clr_overrun = 1'b1;
        @(negedge clk);
        i_clr_overrun = 1'b0;
        check("ovr_clear", o_rx_overrun, 0);
        for (int i = 0; i < 16; i++) rx_expect("ovr_word");
        check("ovr_drained", o_rx_level, 0);

        // 3-clock glitch
        i_rx = 1'b0;
        repeat (3) @(negedge clk);
        i_rx = 1'b1;
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (o_rx_valid) seen = 1'b1;
        end
        check("glitch_valid", seen, 0);
        check("glitch_level", o_rx_level, 0);

        // fill TX FIFO, then reset mid-frame
        i_tx_data = 8'h00;
        i_tx_valid = 1'b1;
        acc = 0;
        k = 0;
        while (o_tx_ready && k < 40) begin
            acc++;
            @(negedge clk);
            k++;
        end
        i_tx_valid = 1'b0;
        check("full_writes", acc, 17);
        check("full_ready", o_tx_ready, 0);
        check("full_level", o_tx_level, 16);
        repeat (40) @(negedge clk);
        check("mid_frame_low", o_tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx", o_tx, 1);
        check("arst_level", o_tx_level, 0);
        check("arst_ready", o_tx_ready, 1);
        check("arst_busy", o_tx_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_tx", o_tx, 1);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
